seq_divider: RTL

- Iterative restoring unsigned divider, one quotient bit per clock.
- Inverse of the 16x16 `multi` multiplier path: takes a 32-bit product-width dividend and a 16-bit divisor, returns quotient and remainder.
- Used in the DBN datapath wherever scaled products must be brought back to operand width (normalisation, averaging).
- Start/done handshake; one operation in flight.

---
 rtl/seq_divider.sv | 118 +++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// Iterative restoring unsigned divider: one quotient bit per clock, start/done handshake.
// Divide by zero finishes immediately with an all-ones quotient and flags div_zero.
module seq_divider #(
  parameter int unsigned DW = 32,
  parameter int unsigned VW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          ready,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_zero
);

  localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] shf_q, shf_d;    // dividend bits out at the top, quotient bits in at the bottom
  logic [VW-1:0] rem_q, rem_d;
  logic [VW-1:0] dvs_q, dvs_d;
  logic [DW-1:0] quot_q, quot_d;
  logic [VW-1:0] remo_q, remo_d;
  logic          dz_q, dz_d;

  logic [VW:0]   part, diff;
  logic          qbit;
  logic [VW-1:0] rem_nxt;
  logic [DW-1:0] shf_nxt;

  // One restoring step; the extra partial-remainder bit keeps the compare exact.
  always_comb begin
    part    = {rem_q, shf_q[DW-1]};
    diff    = part - {1'b0, dvs_q};
    qbit    = (part >= {1'b0, dvs_q});
    rem_nxt = qbit ? diff[VW-1:0] : part[VW-1:0];
    shf_nxt = {shf_q[DW-2:0], qbit};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shf_d   = shf_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dz_d    = dz_q;
    case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start) begin
          if (divisor == '0) begin
            quot_d  = '1;
            remo_d  = dividend[VW-1:0];
            dz_d    = 1'b1;
            state_d = StDone;
          end else begin
            shf_d   = dividend;
            rem_d   = '0;
            dvs_d   = divisor;
            cnt_d   = CW'(DW - 1);
            dz_d    = 1'b0;
            state_d = StRun;
          end
        end
      end
      StRun: begin
        shf_d = shf_nxt;
        rem_d = rem_nxt;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          quot_d  = shf_nxt;
          remo_d  = rem_nxt;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      shf_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      remo_q  <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shf_q   <= shf_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dz_q    <= dz_d;
    end
  end

  assign ready     = (state_q != StRun);
  assign busy      = (state_q == StRun);
  assign done      = (state_q == StDone);
  assign quotient  = quot_q;
  assign remainder = remo_q;
  assign div_zero  = dz_q;

endmodule
